// File: rtl/ysyx_mem_arbiter_pkg.sv
// Shared types and codes for the ysyx IFU/LSU memory arbiter.
// Holds state encodings, bus response codes and read-size codes.
package ysyx_mem_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_IFU_AR = 3'd1,
        ST_IFU_R  = 3'd2,
        ST_LSU_AR = 3'd3,
        ST_LSU_R  = 3'd4,
        ST_LSU_W  = 3'd5,
        ST_LSU_B  = 3'd6
    } arb_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] ARSIZE_BYTE = 3'd0;
    localparam logic [2:0] ARSIZE_HALF = 3'd1;
    localparam logic [2:0] ARSIZE_WORD = 3'd2;

    // Only the two narrow strobe patterns map to sub-word sizes; anything else reads a word.
    function automatic logic [2:0] rstrb_to_arsize(input logic [7:0] rstrb);
        case (rstrb)
            8'h01:   return ARSIZE_BYTE;
            8'h03:   return ARSIZE_HALF;
            default: return ARSIZE_WORD;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_rr_pick2.sv
// Two-way round-robin picker: grants requester b when it is alone,
// or on a tie when a was the one served last.
module ysyx_rr_pick2 (
    input  logic req_a,
    input  logic req_b,
    input  logic last_b,
    output logic grant_b
);

    assign grant_b = req_b & (~req_a | ~last_b);

endmodule

// File: rtl/ysyx_mem_arbiter.sv
// Serialises IFU fetches and LSU loads/stores onto one AXI4-Lite-style manager port.
// Handshake rule: a transfer happens in the cycle where valid and ready are both high;
// bus valids come straight from the state register and never drop before their ready.
module ysyx_mem_arbiter
    import ysyx_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] ifu_araddr,
    input  logic              ifu_arvalid,
    output logic [DATA_W-1:0] ifu_rdata,
    output logic              ifu_rvalid,

    input  logic [ADDR_W-1:0] lsu_araddr,
    input  logic              lsu_arvalid,
    input  logic [7:0]        lsu_rstrb,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_rvalid,

    input  logic [ADDR_W-1:0] lsu_awaddr,
    input  logic              lsu_awvalid,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [7:0]        lsu_wstrb,
    input  logic              lsu_wvalid,
    output logic              lsu_wready,

    output logic [ADDR_W-1:0] bus_araddr,
    output logic [2:0]        bus_arsize,
    output logic              bus_arvalid,
    input  logic              bus_arready,

    input  logic [DATA_W-1:0] bus_rdata,
    input  logic [1:0]        bus_rresp,
    input  logic              bus_rvalid,
    output logic              bus_rready,

    output logic [ADDR_W-1:0] bus_awaddr,
    output logic              bus_awvalid,
    input  logic              bus_awready,

    output logic [DATA_W-1:0] bus_wdata,
    output logic [3:0]        bus_wstrb,
    output logic              bus_wvalid,
    input  logic              bus_wready,

    input  logic [1:0]        bus_bresp,
    input  logic              bus_bvalid,
    output logic              bus_bready,

    output logic              bus_err_o,
    output logic [2:0]        state_dbg
);

    arb_state_e        state_q, state_d;
    logic              last_lsu_q;
    logic              aw_done_q, w_done_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        wstrb_q;
    logic [2:0]        arsize_q;

    logic ifu_req, lsu_wr_req, lsu_rd_req, lsu_req, grant_lsu;
    logic aw_hs, w_hs, aw_ok, w_ok, r_hs, b_hs;
    logic unused_wstrb_hi;

    assign ifu_req    = ifu_arvalid;
    assign lsu_wr_req = lsu_awvalid & lsu_wvalid;
    assign lsu_rd_req = lsu_arvalid;
    assign lsu_req    = lsu_wr_req | lsu_rd_req;

    // The bus is 32 bits wide, so the upper store strobes carry no information.
    assign unused_wstrb_hi = ^lsu_wstrb[7:4];

    ysyx_rr_pick2 u_pick (
        .req_a   (ifu_req),
        .req_b   (lsu_req),
        .last_b  (last_lsu_q),
        .grant_b (grant_lsu)
    );

    assign aw_hs = bus_awvalid & bus_awready;
    assign w_hs  = bus_wvalid & bus_wready;
    assign aw_ok = aw_done_q | aw_hs;
    assign w_ok  = w_done_q | w_hs;
    assign r_hs  = bus_rready & bus_rvalid;
    assign b_hs  = bus_bready & bus_bvalid;

    assign bus_araddr = addr_q;
    assign bus_awaddr = addr_q;
    assign bus_arsize = arsize_q;
    assign bus_wdata  = wdata_q;
    assign bus_wstrb  = wstrb_q;
    assign state_dbg  = state_q;

    always_comb begin
        state_d     = state_q;
        bus_arvalid = 1'b0;
        bus_rready  = 1'b0;
        bus_awvalid = 1'b0;
        bus_wvalid  = 1'b0;
        bus_bready  = 1'b0;
        ifu_rvalid  = 1'b0;
        lsu_rvalid  = 1'b0;
        lsu_wready  = 1'b0;
        ifu_rdata   = '0;
        lsu_rdata   = '0;
        case (state_q)
            ST_IDLE: begin
                if (grant_lsu)
                    state_d = lsu_wr_req ? ST_LSU_W : ST_LSU_AR;
                else if (ifu_req)
                    state_d = ST_IFU_AR;
            end
            ST_IFU_AR: begin
                bus_arvalid = 1'b1;
                if (bus_arready) state_d = ST_IFU_R;
            end
            ST_IFU_R: begin
                bus_rready = 1'b1;
                ifu_rdata  = bus_rdata;
                // A response arriving while reset is held is dropped silently.
                ifu_rvalid = bus_rvalid & ~rst;
                if (bus_rvalid) state_d = ST_IDLE;
            end
            ST_LSU_AR: begin
                bus_arvalid = 1'b1;
                if (bus_arready) state_d = ST_LSU_R;
            end
            ST_LSU_R: begin
                bus_rready = 1'b1;
                lsu_rdata  = bus_rdata;
                lsu_rvalid = bus_rvalid & ~rst;
                if (bus_rvalid) state_d = ST_IDLE;
            end
            ST_LSU_W: begin
                bus_awvalid = ~aw_done_q;
                bus_wvalid  = ~w_done_q;
                if (aw_ok & w_ok) state_d = ST_LSU_B;
            end
            ST_LSU_B: begin
                bus_bready = 1'b1;
                lsu_wready = bus_bvalid & ~rst;
                if (bus_bvalid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            last_lsu_q <= 1'b1;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            arsize_q   <= '0;
            bus_err_o  <= 1'b0;
        end else begin
            state_q <= state_d;

            if (state_q == ST_IDLE) begin
                if (grant_lsu) begin
                    if (lsu_wr_req) begin
                        addr_q  <= lsu_awaddr;
                        wdata_q <= lsu_wdata;
                        wstrb_q <= lsu_wstrb[3:0];
                    end else begin
                        addr_q   <= lsu_araddr;
                        arsize_q <= rstrb_to_arsize(lsu_rstrb);
                    end
                end else if (ifu_req) begin
                    addr_q   <= ifu_araddr;
                    arsize_q <= ARSIZE_WORD;
                end
            end

            // Flags stay set until both write channels are through, then clear for the next store.
            if (state_q == ST_LSU_W && !(aw_ok && w_ok)) begin
                aw_done_q <= aw_ok;
                w_done_q  <= w_ok;
            end else begin
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end

            if (ifu_rvalid)
                last_lsu_q <= 1'b0;
            else if (lsu_rvalid || lsu_wready)
                last_lsu_q <= 1'b1;

            if ((r_hs && bus_rresp != RESP_OKAY) || (b_hs && bus_bresp != RESP_OKAY))
                bus_err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ysyx_mem_arbiter.sv
// Directed bench for ysyx_mem_arbiter: reset, solo fetch, tie, skewed store,
// error stickiness, fairness and reset during a read.
module tb_ysyx_mem_arbiter;
    import ysyx_mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ifu_araddr;
    logic        ifu_arvalid;
    logic [31:0] ifu_rdata;
    logic        ifu_rvalid;
    logic [31:0] lsu_araddr;
    logic        lsu_arvalid;
    logic [7:0]  lsu_rstrb;
    logic [31:0] lsu_rdata;
    logic        lsu_rvalid;
    logic [31:0] lsu_awaddr;
    logic        lsu_awvalid;
    logic [31:0] lsu_wdata;
    logic [7:0]  lsu_wstrb;
    logic        lsu_wvalid;
    logic        lsu_wready;
    logic [31:0] bus_araddr;
    logic [2:0]  bus_arsize;
    logic        bus_arvalid;
    logic        bus_arready;
    logic [31:0] bus_rdata;
    logic [1:0]  bus_rresp;
    logic        bus_rvalid;
    logic        bus_rready;
    logic [31:0] bus_awaddr;
    logic        bus_awvalid;
    logic        bus_awready;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_wvalid;
    logic        bus_wready;
    logic [1:0]  bus_bresp;
    logic        bus_bvalid;
    logic        bus_bready;
    logic        bus_err_o;
    logic [2:0]  state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    ysyx_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid),
        .ifu_rdata(ifu_rdata), .ifu_rvalid(ifu_rvalid),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_rstrb(lsu_rstrb),
        .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid),
        .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid),
        .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid),
        .lsu_wready(lsu_wready),
        .bus_araddr(bus_araddr), .bus_arsize(bus_arsize),
        .bus_arvalid(bus_arvalid), .bus_arready(bus_arready),
        .bus_rdata(bus_rdata), .bus_rresp(bus_rresp),
        .bus_rvalid(bus_rvalid), .bus_rready(bus_rready),
        .bus_awaddr(bus_awaddr), .bus_awvalid(bus_awvalid), .bus_awready(bus_awready),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_wvalid(bus_wvalid), .bus_wready(bus_wready),
        .bus_bresp(bus_bresp), .bus_bvalid(bus_bvalid), .bus_bready(bus_bready),
        .bus_err_o(bus_err_o), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Inputs change 2ns after the rising edge; checks run 1ns later, well before the next edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        ifu_araddr  = '0; ifu_arvalid = 1'b0;
        lsu_araddr  = '0; lsu_arvalid = 1'b0; lsu_rstrb = 8'h0f;
        lsu_awaddr  = '0; lsu_awvalid = 1'b0;
        lsu_wdata   = '0; lsu_wstrb   = '0; lsu_wvalid = 1'b0;
        bus_arready = 1'b0; bus_rdata = '0; bus_rresp = 2'b00; bus_rvalid = 1'b0;
        bus_awready = 1'b0; bus_wready = 1'b0;
        bus_bresp   = 2'b00; bus_bvalid = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_valids"},
            {61'd0, bus_arvalid, bus_awvalid, bus_wvalid},
            64'd0);
        chk({tag, "_readies"},
            {59'd0, bus_rready, bus_bready, ifu_rvalid, lsu_rvalid, lsu_wready},
            64'd0);
    endtask

    initial begin
        logic [31:0] exp_addr;
        logic [2:0]  exp_size;
        logic        exp_lsu;

        // Reset state
        do_reset();
        settle();
        chk("rst_state", state_dbg, ST_IDLE);
        chk_quiet("rst");
        chk("rst_araddr", bus_araddr, 0);
        chk("rst_wdata", bus_wdata, 0);
        chk("rst_err", bus_err_o, 0);

        // IFU alone
        ifu_araddr = 32'h8000_0000; ifu_arvalid = 1'b1; bus_arready = 1'b1;
        settle();
        chk("ifu_c0_arvalid", bus_arvalid, 0);
        tick(); settle();
        chk("ifu_c1_arvalid", bus_arvalid, 1);
        chk("ifu_c1_araddr", bus_araddr, 32'h8000_0000);
        chk("ifu_c1_arsize", bus_arsize, 2);
        tick();
        bus_rvalid = 1'b1; bus_rdata = 32'h0000_0413;
        settle();
        chk("ifu_c2_rready", bus_rready, 1);
        chk("ifu_c2_rvalid", ifu_rvalid, 1);
        chk("ifu_c2_rdata", ifu_rdata, 32'h413);
        chk("ifu_c2_lsu_rvalid", lsu_rvalid, 0);
        tick();
        ifu_arvalid = 1'b0; bus_rvalid = 1'b0;
        settle();
        chk("ifu_c3_rvalid", ifu_rvalid, 0);
        chk("ifu_c3_state", state_dbg, ST_IDLE);

        // Tie after reset, LSU leg returns SLVERR
        do_reset();
        ifu_araddr = 32'h8000_0004; ifu_arvalid = 1'b1;
        lsu_araddr = 32'h8000_1000; lsu_arvalid = 1'b1; lsu_rstrb = 8'h0f;
        bus_arready = 1'b1;
        tick(); settle();
        chk("tie_first_state", state_dbg, ST_IFU_AR);
        chk("tie_first_addr", bus_araddr, 32'h8000_0004);
        tick();
        bus_rvalid = 1'b1; bus_rdata = 32'h1111_2222;
        settle();
        chk("tie_ifu_rvalid", ifu_rvalid, 1);
        tick();
        ifu_arvalid = 1'b0; bus_rvalid = 1'b0;
        settle();
        chk("tie_gap_arvalid", bus_arvalid, 0);
        tick(); settle();
        chk("tie_lsu_arvalid", bus_arvalid, 1);
        chk("tie_lsu_addr", bus_araddr, 32'h8000_1000);
        chk("tie_lsu_arsize", bus_arsize, 2);
        tick();
        bus_rvalid = 1'b1; bus_rdata = 32'hdead_beef; bus_rresp = 2'b10;
        settle();
        chk("err_lsu_rvalid", lsu_rvalid, 1);
        chk("err_lsu_rdata", lsu_rdata, 32'hdead_beef);
        chk("err_ifu_rvalid", ifu_rvalid, 0);
        tick();
        lsu_arvalid = 1'b0; bus_rvalid = 1'b0; bus_rresp = 2'b00;
        settle();
        chk("err_sticky_set", bus_err_o, 1);

        // Store with skewed handshakes
        lsu_awaddr = 32'ha000_03f8; lsu_wdata = 32'h41; lsu_wstrb = 8'h01;
        lsu_awvalid = 1'b1; lsu_wvalid = 1'b1;
        bus_awready = 1'b1; bus_wready = 1'b0;
        tick(); settle();
        chk("st_c1_awvalid", bus_awvalid, 1);
        chk("st_c1_wvalid", bus_wvalid, 1);
        chk("st_c1_awaddr", bus_awaddr, 32'ha000_03f8);
        chk("st_c1_wdata", bus_wdata, 32'h41);
        chk("st_c1_wstrb", bus_wstrb, 4'h1);
        tick();
        bus_awready = 1'b0;
        settle();
        chk("st_c2_awvalid", bus_awvalid, 0);
        chk("st_c2_wvalid", bus_wvalid, 1);
        tick();
        bus_wready = 1'b1;
        settle();
        chk("st_c3_wvalid", bus_wvalid, 1);
        chk("st_c3_state", state_dbg, ST_LSU_W);
        tick();
        bus_wready = 1'b0;
        settle();
        chk("st_c4_wvalid", bus_wvalid, 0);
        chk("st_c4_bready", bus_bready, 1);
        chk("st_c4_wready_early", lsu_wready, 0);
        bus_bvalid = 1'b1;
        settle();
        chk("st_c4_wready", lsu_wready, 1);
        tick();
        lsu_awvalid = 1'b0; lsu_wvalid = 1'b0; bus_bvalid = 1'b0;
        settle();
        chk("st_c5_wready", lsu_wready, 0);
        chk("st_c5_state", state_dbg, ST_IDLE);
        chk("st_err_still", bus_err_o, 1);

        // Fairness: both hold requests; LSU was last served so IFU goes first
        ifu_araddr = 32'h8000_0100; ifu_arvalid = 1'b1;
        lsu_araddr = 32'h8000_2000; lsu_arvalid = 1'b1;
        bus_arready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_lsu  = (i % 2) == 1;
            lsu_rstrb = (i == 1) ? 8'h01 : 8'h03;
            exp_addr = exp_lsu ? 32'h8000_2000 : 32'h8000_0100;
            exp_size = !exp_lsu ? 3'd2 : ((i == 1) ? 3'd0 : 3'd1);
            tick(); settle();
            chk($sformatf("fair%0d_addr", i), bus_araddr, exp_addr);
            chk($sformatf("fair%0d_size", i), bus_arsize, exp_size);
            tick();
            bus_rvalid = 1'b1; bus_rdata = 32'h100 + i;
            settle();
            chk($sformatf("fair%0d_ifu", i), ifu_rvalid, !exp_lsu);
            chk($sformatf("fair%0d_lsu", i), lsu_rvalid, exp_lsu);
            tick();
            bus_rvalid = 1'b0;
            settle();
            chk($sformatf("fair%0d_idle", i), state_dbg, ST_IDLE);
        end
        chk("fair_err_sticky", bus_err_o, 1);

        // Reset while in IFU_R
        ifu_arvalid = 1'b0; lsu_arvalid = 1'b0;
        ifu_araddr = 32'h8000_0200; ifu_arvalid = 1'b1;
        tick(); tick();
        settle();
        chk("rmr_in_ifu_r", state_dbg, ST_IFU_R);
        rst = 1'b1; ifu_arvalid = 1'b0;
        tick();
        rst = 1'b0;
        bus_rvalid = 1'b1; bus_rdata = 32'hcafe_f00d;
        settle();
        chk("rmr_state", state_dbg, ST_IDLE);
        chk_quiet("rmr");
        chk("rmr_err_cleared", bus_err_o, 0);
        tick();
        bus_rvalid = 1'b0;
        settle();
        chk("rmr_no_pulse", ifu_rvalid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
